// File: rtl/fifo_fwft_rd_stage.sv
// First-word-fall-through read stage behind the async FIFO: credit-limited prefetch buffer, valid/ready output.
// Optional macro FWFT_LEVEL_EN adds out_level (buffer occupancy) and out_full.
module fifo_fwft_rd_stage #(
    parameter int WIDTH     = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic             rd_clk,
    input  logic             rd_rst,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef FWFT_LEVEL_EN
    ,
    output logic [$clog2(BUF_DEPTH):0] out_level,
    output logic                       out_full
`endif
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             inflight;
    logic             push;
    logic             pop;
    logic [CW-1:0]    credit_used;

    assign push      = inflight;
    assign pop       = out_valid & out_ready;
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? buf_mem[rptr] : '0;

    // Slots already committed after this cycle: stored + arriving - leaving.
    // pop implies count >= 1, so the subtraction cannot wrap.
    assign credit_used = count + CW'(inflight) - CW'(pop);
    assign fifo_rd_en  = ~fifo_empty & ~rd_rst & (credit_used < CW'(BUF_DEPTH));

    // Stage boundary: issued read returns next cycle as push
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge rd_clk) begin
        if (push) begin
            buf_mem[wptr] <= fifo_rd_data;
        end
    end

`ifdef FWFT_LEVEL_EN
    assign out_level = count;
    assign out_full  = (count == CW'(BUF_DEPTH));
`endif

endmodule

// File: tb/tb_fifo_fwft_rd_stage.sv
// Directed bench for fifo_fwft_rd_stage with a behavioural upstream FIFO read port.
module tb_fifo_fwft_rd_stage;

    localparam int WIDTH     = 32;
    localparam int BUF_DEPTH = 2;
    localparam int LW        = $clog2(BUF_DEPTH) + 1;

    logic             rd_clk = 1'b0;
    logic             rd_rst = 1'b1;
    logic             fifo_empty = 1'b1;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_rd_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
`ifdef FWFT_LEVEL_EN
    logic [LW-1:0]    out_level;
    logic             out_full;
`endif

    int errors = 0;
    int checks = 0;

    always #5 rd_clk = ~rd_clk;

    fifo_fwft_rd_stage #(.WIDTH(WIDTH), .BUF_DEPTH(BUF_DEPTH)) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
`ifdef FWFT_LEVEL_EN
        ,
        .out_level    (out_level),
        .out_full     (out_full)
`endif
    );

    // Upstream FIFO: words fifo_mem[0..fifo_avail-1], registered empty, one-cycle read latency
    logic [WIDTH-1:0] fifo_mem [0:1023];
    int fifo_avail = 0;
    int fifo_rd    = 0;

    always @(posedge rd_clk) begin
        int rp_n;
        rp_n = fifo_rd + (fifo_rd_en ? 1 : 0);
        if (fifo_rd_en) fifo_rd_data <= fifo_mem[fifo_rd];
        fifo_rd    <= rp_n;
        fifo_empty <= (rp_n >= fifo_avail);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge rd_clk) begin
        #2;
        chk("rd_en_while_empty", {63'b0, fifo_rd_en & fifo_empty}, 64'd0);
    end

    logic [31:0]      exp_rd_en [6] = '{1, 1, 1, 0, 0, 0};
    logic [31:0]      exp_valid [6] = '{0, 0, 1, 1, 1, 0};
    logic [WIDTH-1:0] exp_data  [6] = '{0, 0, 32'hA1, 32'hA2, 32'hA3, 0};
    int               pulses;
    int               got;
    logic             hold;
    logic [WIDTH-1:0] hold_data;

    initial begin
        fifo_mem[0] = 32'hA1;
        fifo_mem[1] = 32'hA2;
        fifo_mem[2] = 32'hA3;
        for (int i = 0; i < 8; i++)    fifo_mem[3 + i]    = 32'h100 + i;
        for (int i = 0; i < 1000; i++) fifo_mem[11 + i]   = i;
        for (int i = 0; i < 4; i++)    fifo_mem[1011 + i] = 32'h200 + i;
        for (int i = 0; i < 3; i++)    fifo_mem[1015 + i] = 32'h300 + i;

        // Reset held with an empty FIFO
        for (int i = 0; i < 10; i++) begin
            @(negedge rd_clk); #1;
            chk("rst_rd_en", fifo_rd_en, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_data", out_data, 0);
`ifdef FWFT_LEVEL_EN
            chk("rst_level", out_level, 0);
            chk("rst_full", out_full, 0);
`endif
        end

        // Three words, consumer always ready: first-word latency and streaming
        @(negedge rd_clk); rd_rst = 1'b0; out_ready = 1'b1; fifo_avail = 3; #1;
        chk("pre_rd_en", fifo_rd_en, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge rd_clk); #1;
            chk("stream_rd_en", fifo_rd_en, exp_rd_en[i]);
            chk("stream_valid", out_valid, exp_valid[i]);
            if (exp_valid[i] != 0) chk("stream_data", out_data, exp_data[i]);
        end

        // Eight words under backpressure: only two reads fit
        @(negedge rd_clk); out_ready = 1'b0; fifo_avail = 11; #1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge rd_clk); #1;
            pulses += int'(fifo_rd_en);
        end
        chk("bp_pulses", pulses, 2);
        chk("bp_rd_en_idle", fifo_rd_en, 0);
        chk("bp_valid", out_valid, 1);
        chk("bp_head", out_data, 32'h100);
        @(negedge rd_clk); out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("drain_valid", out_valid, 1);
            chk("drain_data", out_data, 32'h100 + i);
            @(negedge rd_clk);
        end
        #1;
        chk("drain_end_valid", out_valid, 0);

        // 1000 words with random consumer readiness
        fifo_avail = 1011;
        got  = 0;
        hold = 1'b0;
        hold_data = '0;
        for (int cyc = 0; cyc < 6000 && got < 1000; cyc++) begin
            @(negedge rd_clk); out_ready = 1'($urandom_range(0, 1)); #1;
            if (hold) begin
                chk("stable_valid", out_valid, 1);
                chk("stable_data", out_data, hold_data);
            end
            if (out_valid && out_ready) begin
                chk("rand_data", out_data, got);
                got++;
            end
            hold = out_valid & ~out_ready;
            hold_data = out_data;
        end
        chk("rand_count", got, 1000);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge rd_clk); #1;
            chk("rand_no_dup", out_valid, 0);
        end

        // Reset while one word is buffered and another is in flight
        @(negedge rd_clk); out_ready = 1'b0; fifo_avail = 1015; #1;
        @(negedge rd_clk); #1;
        chk("mid_rd_en_a", fifo_rd_en, 1);
        @(negedge rd_clk); #1;
        chk("mid_rd_en_b", fifo_rd_en, 1);
        @(negedge rd_clk); rd_rst = 1'b1; #1;
        chk("mid_rst_rd_en", fifo_rd_en, 0);
        chk("mid_pre_valid", out_valid, 1);
        chk("mid_pre_data", out_data, 32'h200);
        @(negedge rd_clk); rd_rst = 1'b0; out_ready = 1'b1; #1;
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_rd_en", fifo_rd_en, 1);
        @(negedge rd_clk); #1;
        chk("post_rst_valid1", out_valid, 0);
        @(negedge rd_clk); #1;
        chk("post_rst_valid2", out_valid, 1);
        chk("post_rst_data2", out_data, 32'h202);
        @(negedge rd_clk); #1;
        chk("post_rst_data3", out_data, 32'h203);
        @(negedge rd_clk); #1;
        chk("post_rst_end", out_valid, 0);

`ifdef FWFT_LEVEL_EN
        // Occupancy with the consumer stalled
        @(negedge rd_clk); out_ready = 1'b0; fifo_avail = 1018; #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge rd_clk); #1;
            chk("level", out_level, (i < 2) ? 0 : i - 1);
            chk("full", out_full, (i == 3) ? 1 : 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
